// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the existing transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, framing/overrun detection, one-entry
// holding register presented on a valid/ready port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    input  logic                      ready,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    uart_rx_state_t            state, state_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic [IDX_W-1:0]          idx, idx_n;
    logic [UART_DATA_BITS-1:0] sh, sh_n;
    logic [UART_DATA_BITS-1:0] data_n;
    logic                      valid_n, frame_err_n, overrun_n, busy_n;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        sh_n        = sh;
        data_n      = data;
        valid_n     = valid & ~ready;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                // Mid-start-bit check rejects short glitches without flagging.
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n     = '0;
                    sh_n[idx] = rx_s;
                    idx_n     = idx + IDX_W'(1);
                    if (idx == IDX_W'(7)) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                        // A same-cycle drain frees the holding register for the new byte.
                        if (!valid || ready) begin
                            data_n  = sh;
                            valid_n = 1'b1;
                        end else begin
                            overrun_n = 1'b1;
                        end
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = BREAK;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule
